// File: rtl/shift_reg_seq_ctrl.sv
// Command sequencer for one universal shift register: accepts LOAD/TX/RX commands and
// drives enable/mode/load for as many cycles as each operation needs.
//
// state      | meaning
// S_IDLE     | waiting for a command, cmd_ready high
// S_LOAD     | one-cycle parallel load (PIPO)
// S_TX_LOAD  | one-cycle parallel load before serialising
// S_TX_SHIFT | presenting serial bits, one shift per tx handshake
// S_RX_SHIFT | shifting in serial bits, one shift per valid rx bit
// S_DONE     | done pulse, capture parallel output into result
module shift_reg_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             tx_bit_valid,
    input  logic             tx_bit_ready,
    output logic             tx_bit,
    input  logic             rx_bit_valid,
    input  logic             rx_bit,
    output logic             sr_enable,
    output logic [1:0]       sr_mode,
    output logic             sr_load,
    output logic             sr_siso_in,
    output logic [WIDTH-1:0] sr_par_in,
    input  logic             sr_siso_out,
    input  logic [WIDTH-1:0] sr_par_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TX_LOAD,
        S_TX_SHIFT,
        S_RX_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sr_mode   <= 2'b11;
            sr_par_in <= '0;
            result    <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sr_par_in <= cmd_data;
                        sr_mode   <= cmd_op;
                        cnt       <= '0;
                        case (cmd_op)
                            2'b11:   state <= S_LOAD;
                            2'b10:   state <= S_TX_LOAD;
                            default: state <= S_RX_SHIFT;
                        endcase
                    end
                end
                S_LOAD:    state <= S_DONE;
                S_TX_LOAD: state <= S_TX_SHIFT;
                S_TX_SHIFT: begin
                    if (tx_bit_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_DONE;
                    end
                end
                S_RX_SHIFT: begin
                    if (rx_bit_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result <= sr_par_out;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Enables follow the bit handshakes combinationally so a stalled bit never shifts.
    always_comb begin
        sr_enable    = 1'b0;
        sr_load      = 1'b0;
        tx_bit_valid = 1'b0;
        tx_bit       = 1'b0;
        done         = 1'b0;
        case (state)
            S_LOAD, S_TX_LOAD: begin
                sr_enable = !abort;
                sr_load   = 1'b1;
            end
            S_TX_SHIFT: begin
                tx_bit_valid = 1'b1;
                tx_bit       = sr_siso_out;
                sr_enable    = tx_bit_ready && !abort;
            end
            S_RX_SHIFT: sr_enable = rx_bit_valid && !abort;
            S_DONE:     done      = !abort;
            default: ;
        endcase
    end

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign sr_siso_in = rx_bit;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl: a behavioural universal shift register plus randomized
// command traffic checked against expectations derived from the command semantics.
module tb_shift_reg_seq_ctrl;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             abort = 1'b0;
    logic             tx_bit_valid;
    logic             tx_bit_ready = 1'b0;
    logic             tx_bit;
    logic             rx_bit_valid = 1'b0;
    logic             rx_bit = 1'b0;
    logic             sr_enable;
    logic [1:0]       sr_mode;
    logic             sr_load;
    logic             sr_siso_in;
    logic [WIDTH-1:0] sr_par_in;
    logic             sr_siso_out;
    logic [WIDTH-1:0] sr_par_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int errors = 0;
    int checks = 0;

    shift_reg_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .abort(abort),
        .tx_bit_valid(tx_bit_valid), .tx_bit_ready(tx_bit_ready), .tx_bit(tx_bit),
        .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
        .sr_enable(sr_enable), .sr_mode(sr_mode), .sr_load(sr_load),
        .sr_siso_in(sr_siso_in), .sr_par_in(sr_par_in),
        .sr_siso_out(sr_siso_out), .sr_par_out(sr_par_out),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Universal shift register the controller is meant to drive.
    logic [WIDTH-1:0] sr_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else if (sr_enable) begin
            if (sr_load) sr_q <= sr_par_in;
            else if (sr_mode == 2'b00) sr_q <= {sr_siso_in, sr_q[WIDTH-1:1]};
            else if (sr_mode == 2'b01) sr_q <= {sr_q[WIDTH-2:0], sr_siso_in};
            else if (sr_mode == 2'b10) sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        end
    end
    assign sr_siso_out = (sr_mode == 2'b01) ? sr_q[WIDTH-1] : sr_q[0];
    assign sr_par_out  = sr_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data);
        bit ok;
        ok = 0;
        cmd_op = op;
        cmd_data = data;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sample();
            if (cmd_ready === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready never rose for op %0d", op);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_data = WIDTH'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0 || sr_enable !== 1'b0 || sr_load !== 1'b0 || tx_bit_valid !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: done=%b en=%b load=%b txv=%b exp all 0", done, sr_enable, sr_load, tx_bit_valid); end
        checks++; if (sr_mode !== 2'b11) begin errors++; $display("FAIL reset_sr_mode: got %b exp 11", sr_mode); end
        checks++; if (sr_par_in !== '0 || result !== '0) begin
            errors++; $display("FAIL reset_words: par_in=%h result=%h exp 0", sr_par_in, result); end
        sample();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load(input logic [WIDTH-1:0] data);
        issue(2'b11, data);
        sample();
        checks++; if (sr_load !== 1'b1 || sr_enable !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL load_strobe: load=%b en=%b done=%b exp 1 1 0", sr_load, sr_enable, done); end
        checks++; if (sr_mode !== 2'b11 || sr_par_in !== data) begin
            errors++; $display("FAIL load_latch: mode=%b par_in=%h exp 11 %h", sr_mode, sr_par_in, data); end
        tick();
        sample();
        checks++; if (done !== 1'b1 || sr_load !== 1'b0 || sr_enable !== 1'b0) begin
            errors++; $display("FAIL load_done: done=%b load=%b en=%b exp 1 0 0", done, sr_load, sr_enable); end
        tick();
        sample();
        checks++; if (result !== data || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL load_result: result=%h done=%b rdy=%b exp %h 0 1", result, done, cmd_ready, data); end
        tick();
    endtask

    // pat: 0 ready always, 1 ready every other cycle, 2 random ready
    task automatic test_tx(input logic [WIDTH-1:0] data, input int pat);
        int n, cyc;
        bit seen_done, rdy;
        issue(2'b10, data);
        sample();
        checks++; if (sr_load !== 1'b1 || sr_enable !== 1'b1 || tx_bit_valid !== 1'b0) begin
            errors++; $display("FAIL tx_load: load=%b en=%b txv=%b exp 1 1 0", sr_load, sr_enable, tx_bit_valid); end
        tick();
        n = 0; cyc = 0; seen_done = 0;
        while (!seen_done && cyc < 200) begin
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? cyc[0] : 1'($urandom);
            tx_bit_ready = rdy;
            sample();
            if (done === 1'b1) begin
                seen_done = 1;
                checks++; if (sr_enable !== 1'b0 || tx_bit_valid !== 1'b0) begin
                    errors++; $display("FAIL tx_done_strobes: en=%b txv=%b exp 0 0", sr_enable, tx_bit_valid); end
            end else begin
                checks++; if (tx_bit_valid !== 1'b1 || n >= WIDTH) begin
                    errors++; $display("FAIL tx_valid: txv=%b bits_sent=%0d exp 1 and <%0d", tx_bit_valid, n, WIDTH); end
                else begin
                    checks++; if (tx_bit !== data[n]) begin
                        errors++; $display("FAIL tx_bit: bit %0d got %b exp %b", n, tx_bit, data[n]); end
                end
                checks++; if (sr_enable !== rdy) begin
                    errors++; $display("FAIL tx_enable: got %b exp %b", sr_enable, rdy); end
                if (rdy) n++;
            end
            tick();
            cyc++;
        end
        tx_bit_ready = 1'b0;
        checks++; if (!seen_done || n != WIDTH) begin
            errors++; $display("FAIL tx_count: done_seen=%0d bits=%0d exp 1 %0d", seen_done, n, WIDTH); end
        if (pat == 0) begin
            checks++; if (cyc != WIDTH + 1) begin
                errors++; $display("FAIL tx_latency: cycles=%0d exp %0d", cyc, WIDTH + 1); end
        end
    endtask

    task automatic test_rx(input logic [WIDTH-1:0] data, input bit left, input bit gaps);
        int n, cyc;
        bit seen_done, v, b;
        logic [WIDTH-1:0] exp;
        bit sent[WIDTH];
        issue(left ? 2'b01 : 2'b00, data);
        n = 0; cyc = 0; seen_done = 0;
        while (!seen_done && cyc < 200) begin
            v = gaps ? ($urandom_range(2) != 0) : 1'b1;
            if (n >= WIDTH) v = 1'b0;
            b = !v ? 1'($urandom) : left ? data[WIDTH-1-n] : data[n];
            rx_bit_valid = v;
            rx_bit = b;
            sample();
            if (done === 1'b1) seen_done = 1;
            else begin
                checks++; if (sr_enable !== v || sr_siso_in !== b || busy !== 1'b1) begin
                    errors++; $display("FAIL rx_enable: en=%b si=%b busy=%b exp %b %b 1", sr_enable, sr_siso_in, busy, v, b); end
                if (v) begin sent[n] = b; n++; end
            end
            tick();
            cyc++;
        end
        rx_bit_valid = 1'b0;
        exp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (left) exp[WIDTH-1-i] = sent[i];
            else exp[i] = sent[i];
        end
        sample();
        checks++; if (!seen_done || n != WIDTH || result !== exp) begin
            errors++; $display("FAIL rx_result: done_seen=%0d bits=%0d result=%h exp %h", seen_done, n, result, exp); end
        tick();
    endtask

    task automatic test_abort();
        logic [WIDTH-1:0] pre;
        pre = WIDTH'($urandom) | 16'h0100;
        test_load(pre);
        issue(2'b10, 16'hF0F0);
        tick();
        tx_bit_ready = 1'b1;
        repeat (5) tick();
        abort = 1'b1;
        sample();
        checks++; if (sr_enable !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_cycle: en=%b done=%b exp 0 0", sr_enable, done); end
        tick();
        abort = 1'b0;
        tx_bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== pre) begin
                errors++; $display("FAIL abort_idle: rdy=%b busy=%b done=%b result=%h exp 1 0 0 %h", cmd_ready, busy, done, result, pre); end
            tick();
        end
        test_load(16'h5A3C);
    endtask

    task automatic test_reset_mid();
        issue(2'b00, 16'hBEEF);
        rx_bit_valid = 1'b1;
        repeat (7) begin rx_bit = 1'($urandom); tick(); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sr_enable !== 1'b0 || sr_load !== 1'b0 || tx_bit_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: rdy=%b busy=%b done=%b en=%b load=%b txv=%b exp 1 0 0 0 0 0",
                cmd_ready, busy, done, sr_enable, sr_load, tx_bit_valid); end
        checks++; if (sr_mode !== 2'b11 || sr_par_in !== '0 || result !== '0) begin
            errors++; $display("FAIL midrst_words: mode=%b par_in=%h result=%h exp 11 0 0", sr_mode, sr_par_in, result); end
        rx_bit_valid = 1'b0;
        sample();
        rst = 1'b1;
        tick();
        test_tx(WIDTH'($urandom), 0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b;
        a = WIDTH'($urandom);
        b = ~a;
        cmd_op = 2'b11; cmd_data = a; cmd_valid = 1'b1;
        sample();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b exp 1", cmd_ready); end
        tick();
        cmd_data = b;
        sample();
        checks++; if (cmd_ready !== 1'b0 || sr_par_in !== a) begin
            errors++; $display("FAIL b2b_busy1: rdy=%b par_in=%h exp 0 %h", cmd_ready, sr_par_in, a); end
        tick();
        sample();
        checks++; if (cmd_ready !== 1'b0 || done !== 1'b1 || sr_par_in !== a) begin
            errors++; $display("FAIL b2b_busy2: rdy=%b done=%b par_in=%h exp 0 1 %h", cmd_ready, done, sr_par_in, a); end
        tick();
        sample();
        checks++; if (cmd_ready !== 1'b1 || result !== a) begin
            errors++; $display("FAIL b2b_second_accept: rdy=%b result=%h exp 1 %h", cmd_ready, result, a); end
        tick();
        cmd_valid = 1'b0;
        sample();
        checks++; if (sr_par_in !== b || sr_load !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_second_load: par_in=%h load=%b busy=%b exp %h 1 1", sr_par_in, sr_load, busy, b); end
        tick();
        sample();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b exp 1", done); end
        tick();
        sample();
        checks++; if (result !== b) begin errors++; $display("FAIL b2b_second_result: got %h exp %h", result, b); end
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load(16'hA5C3);
        repeat (3) test_load(WIDTH'($urandom));
        test_tx(16'h8001, 0);
        test_tx(16'h8001, 1);
        test_tx(WIDTH'($urandom), 2);
        test_rx(16'h1234, 1'b0, 1'b0);
        test_rx(16'h1234, 1'b1, 1'b0);
        test_rx(WIDTH'($urandom), 1'b0, 1'b1);
        test_rx(WIDTH'($urandom), 1'b1, 1'b1);
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
